// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: shared widths and the fetch FSM state encoding.
// The hazard unit and debug logic import this too, so the state
// encoding (RUN=0, DRAIN=1, HALTED=2) must not change.
package fetch_pkg;
    localparam int PC_W = 12;  // PC / instruction-memory address width
    localparam int CU_W = 5;   // control-unit field (instruction bits 18:14)
    localparam int DP_W = 14;  // datapath field (instruction bits 13:0)

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory bus between the fetch sequencer
// and the instruction memory.
//   imem_addr  - word address (driven by the fetch side)
//   imem_cu    - control field of the addressed word
//   imem_dp    - datapath field of the addressed word
//   imem_halt  - addressed word is all zeros
// Modports: master = fetch side, slave = memory side.
interface fetch_sequencer_if
    import fetch_pkg::*;
();
    logic [PC_W-1:0] imem_addr;
    logic [CU_W-1:0] imem_cu;
    logic [DP_W-1:0] imem_dp;
    logic            imem_halt;

    modport master (output imem_addr, input imem_cu, input imem_dp, input imem_halt);
    modport slave  (input imem_addr, output imem_cu, output imem_dp, output imem_halt);
endinterface

// File: rtl/fetch_sequencer_ifid_reg.sv
// ifid_reg: IF/ID pipeline register.
//   clk, rst          - clock, synchronous active-high reset
//   i_en              - capture new instruction (low while stalled)
//   i_flush           - clear contents to a bubble; wins over i_en
//   i_cu, i_dp, i_pc  - control field, datapath field, PC+1 to capture
//   o_cu, o_dp, o_pc  - registered fields
//   o_valid           - register holds a real instruction
module ifid_reg
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_flush,
    input  logic [CU_W-1:0] i_cu,
    input  logic [DP_W-1:0] i_dp,
    input  logic [PC_W-1:0] i_pc,
    output logic [CU_W-1:0] o_cu,
    output logic [DP_W-1:0] o_dp,
    output logic [PC_W-1:0] o_pc,
    output logic            o_valid
);
    logic [CU_W-1:0] r_cu;
    logic [DP_W-1:0] r_dp;
    logic [PC_W-1:0] r_pc;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_cu    <= '0;
            r_dp    <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_cu    <= i_cu;
            r_dp    <= i_dp;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_cu    = r_cu;
    assign o_dp    = r_dp;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller. Owns the PC, addresses
// instruction memory, fills the IF/ID register, applies stalls and
// redirects, and turns an all-zero instruction word into a
// drain-then-halt sequence.
//   clk, rst             - clock, synchronous active-high reset
//   stall                - hold PC and IF/ID
//   redirect/redirect_pc - taken branch/jump and its target (flushes IF/ID)
//   imem                 - instruction-memory bus (master side)
//   ifid_cu/dp/pc/valid  - IF/ID register contents (pc field = PC+1)
//   state                - RUN / DRAIN / HALTED
//   halted               - high in HALTED
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4   // >= 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    fetch_sequencer_if.master  imem,
    output logic [CU_W-1:0]    ifid_cu,
    output logic [DP_W-1:0]    ifid_dp,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output state_t             state,
    output logic               halted
);
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t            r_state, w_state_next;
    logic [PC_W-1:0]   r_pc, w_pc_next, w_pc_inc;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              w_ifid_en, w_ifid_flush;

    // Wraps modulo 2^PC_W by construction.
    assign w_pc_inc = r_pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_next   = r_cnt;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect) begin
                    w_pc_next    = redirect_pc;
                    w_ifid_flush = 1'b1;
                end else if (stall) begin
                    // hold everything; a halt word seen while stalled is not acted on
                end else if (imem.imem_halt) begin
                    // Counter counts DRAIN_CYCLES-1 down to 0, giving exactly
                    // DRAIN_CYCLES cycles in DRAIN.
                    w_ifid_flush = 1'b1;
                    w_cnt_next   = CNT_W'(DRAIN_CYCLES - 1);
                    w_state_next = ST_DRAIN;
                end else begin
                    w_ifid_en = 1'b1;
                    w_pc_next = w_pc_inc;
                end
            end
            ST_DRAIN: begin
                // Stall does not pause the drain; redirect means the halt
                // word was on a wrong path, even on the expiry edge.
                if (redirect) begin
                    w_pc_next    = redirect_pc;
                    w_cnt_next   = '0;
                    w_state_next = ST_RUN;
                    w_ifid_flush = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                // HALTED: only rst leaves this state
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_ifid_en),
        .i_flush (w_ifid_flush),
        .i_cu    (imem.imem_cu),
        .i_dp    (imem.imem_dp),
        .i_pc    (w_pc_inc),
        .o_cu    (ifid_cu),
        .o_dp    (ifid_dp),
        .o_pc    (ifid_pc),
        .o_valid (ifid_valid)
    );

    assign imem.imem_addr = r_pc;
    assign state          = r_state;
    assign halted         = (r_state == ST_HALTED);
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic [CU_W-1:0] ifid_cu;
    logic [DP_W-1:0] ifid_dp;
    logic [PC_W-1:0] ifid_pc;
    logic            ifid_valid;
    state_t          state;
    logic            halted;

    int checks = 0;
    int errors = 0;
    int halt_addr = 8;

    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    // Memory image: every word nonzero except the one at halt_addr.
    function automatic logic [CU_W-1:0] m_cu(int a);
        return (a == halt_addr) ? '0 : CU_W'((a % 31) + 1);
    endfunction
    function automatic logic [DP_W-1:0] m_dp(int a);
        return (a == halt_addr) ? '0 : (DP_W'(14'h2000) | DP_W'(a));
    endfunction

    assign bus.imem_halt = (int'(bus.imem_addr) == halt_addr);
    assign bus.imem_cu   = m_cu(int'(bus.imem_addr));
    assign bus.imem_dp   = m_dp(int'(bus.imem_addr));

    fetch_sequencer #(.DRAIN_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .ifid_cu     (ifid_cu),
        .ifid_dp     (ifid_dp),
        .ifid_pc     (ifid_pc),
        .ifid_valid  (ifid_valid),
        .state       (state),
        .halted      (halted)
    );

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(string tag, int e_pc, int e_valid, int e_state, int e_halted);
        check({tag, " pc"}, int'(bus.imem_addr), e_pc);
        check({tag, " valid"}, int'(ifid_valid), e_valid);
        check({tag, " state"}, int'(state), e_state);
        check({tag, " halted"}, int'(halted), e_halted);
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        rst = 1'b0;
        check_status(tag, 0, 0, 0, 0);
        check({tag, " ifid_pc"}, int'(ifid_pc), 0);
        check({tag, " ifid_cu"}, int'(ifid_cu), 0);
        check({tag, " ifid_dp"}, int'(ifid_dp), 0);
    endtask

    typedef struct {
        logic            stall;
        logic            redirect;
        logic [PC_W-1:0] rpc;
        int              e_pc;
        int              e_ifid_pc;
        int              e_valid;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // Fetch, 3-cycle stall at pc=3, resume, redirect over stall, refetch.
        vecs[0] = '{1'b0, 1'b0, 12'd0, 1, 1, 1};
        vecs[1] = '{1'b0, 1'b0, 12'd0, 2, 2, 1};
        vecs[2] = '{1'b0, 1'b0, 12'd0, 3, 3, 1};
        vecs[3] = '{1'b1, 1'b0, 12'd0, 3, 3, 1};
        vecs[4] = '{1'b1, 1'b0, 12'd0, 3, 3, 1};
        vecs[5] = '{1'b1, 1'b0, 12'd0, 3, 3, 1};
        vecs[6] = '{1'b0, 1'b0, 12'd0, 4, 4, 1};
        vecs[7] = '{1'b1, 1'b1, 12'd5, 5, 0, 0};
        vecs[8] = '{1'b0, 1'b0, 12'd0, 6, 6, 1};

        halt_addr = 8;
        do_reset("reset");
        for (int i = 0; i < 9; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
            tick();
            check_status(t, vecs[i].e_pc, vecs[i].e_valid, 0, 0);
            check({t, " ifid_pc"}, int'(ifid_pc), vecs[i].e_ifid_pc);
            check({t, " ifid_cu"}, int'(ifid_cu),
                  vecs[i].e_valid ? int'(m_cu((vecs[i].e_ifid_pc + 4095) % 4096)) : 0);
            check({t, " ifid_dp"}, int'(ifid_dp),
                  vecs[i].e_valid ? int'(m_dp((vecs[i].e_ifid_pc + 4095) % 4096)) : 0);
        end
        stall = 1'b0; redirect = 1'b0;

        // Redirect while stalled at pc=2: one bubble, then target.
        do_reset("rs2");
        tick(); tick();
        check("s2 pc2", int'(bus.imem_addr), 2);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 12'h005;
        tick();
        stall = 1'b0; redirect = 1'b0;
        check_status("s2 redir", 5, 0, 0, 0);
        tick();
        check_status("s2 tgt", 6, 1, 0, 0);
        check("s2 tgt ifid_pc", int'(ifid_pc), 6);

        // Full drain-then-halt, stall during DRAIN must not pause it.
        do_reset("rs3");
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_status($sformatf("s3 fetch%0d", k), k, 1, 0, 0);
            check($sformatf("s3 fetch%0d ifid_pc", k), int'(ifid_pc), k);
        end
        tick();
        check_status("s3 edge9", 8, 0, 1, 0);
        check("s3 edge9 ifid_cu", int'(ifid_cu), 0);
        stall = 1'b1;
        for (int k = 10; k <= 12; k++) begin
            tick();
            check_status($sformatf("s3 edge%0d", k), 8, 0, 1, 0);
        end
        stall = 1'b0;
        tick();
        check_status("s3 edge13", 8, 0, 2, 1);
        redirect = 1'b1; redirect_pc = 12'h003; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        check_status("s3 halted ignores", 8, 0, 2, 1);
        do_reset("s3 rst in HALTED");

        // Redirect during the second DRAIN cycle.
        for (int k = 1; k <= 9; k++) tick();
        check("s4 drain", int'(state), 1);
        tick();
        redirect = 1'b1; redirect_pc = 12'h002;
        tick();
        redirect = 1'b0;
        check_status("s4 redir", 2, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_status($sformatf("s4 run%0d", k), 3 + k, 1, 0, 0);
        end

        // Redirect on the edge where the drain counter expires.
        do_reset("rs5");
        for (int k = 1; k <= 12; k++) tick();
        check("s5 still drain", int'(state), 1);
        redirect = 1'b1; redirect_pc = 12'h001;
        tick();
        redirect = 1'b0;
        check_status("s5 expiry redir", 1, 0, 0, 0);

        // Mid-DRAIN reset discards the drain.
        do_reset("rs6");
        for (int k = 1; k <= 10; k++) tick();
        check("s6 drain", int'(state), 1);
        do_reset("s6 rst in DRAIN");
        for (int k = 1; k <= 8; k++) tick();
        check_status("s6 refetch", 8, 1, 0, 0);

        // PC wrap: 4095 + 1 = 0.
        halt_addr = 100;
        do_reset("rs7");
        redirect = 1'b1; redirect_pc = 12'hFFF;
        tick();
        redirect = 1'b0;
        check_status("s7 at4095", 4095, 0, 0, 0);
        tick();
        check_status("s7 wrap", 0, 1, 0, 0);
        check("s7 ifid_pc", int'(ifid_pc), 0);
        check("s7 ifid_cu", int'(ifid_cu), int'(m_cu(4095)));
        check("s7 ifid_dp", int'(ifid_dp), int'(m_dp(4095)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
